// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch (I) and load/store (D).
// D wins by default; a streak counter forces an I grant after STARVE_LIMIT back-to-back D grants.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                IReq,
    input  logic [ADDR_W-1:0]   IAddr,
    output logic [DATA_W-1:0]   IData,
    output logic                IDone,
    input  logic                DReq,
    input  logic                DWrite,
    input  logic [ADDR_W-1:0]   DAddr,
    input  logic [DATA_W-1:0]   DWData,
    input  logic [DATA_W/8-1:0] DStrb,
    output logic [DATA_W-1:0]   DRData,
    output logic                DDone,
    output logic                MemEn,
    output logic [DATA_W/8-1:0] MemWe,
    output logic [ADDR_W-1:0]   MemAddr,
    output logic [DATA_W-1:0]   MemWData,
    input  logic [DATA_W-1:0]   MemRData,
    output logic                Busy,
    output logic                Owner
);

    localparam int STK_W = $clog2(STARVE_LIMIT + 1);
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [STK_W-1:0] STK_MAX   = STK_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(RD_LATENCY - 1);

    // IDLE: arbitrate | ACCESS: strobe memory | WAIT: read latency | RESP: done pulse
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    logic [STK_W-1:0] streak;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_write;
    logic             grant_i;

    assign grant_i = IReq && (!DReq || streak == STK_MAX);
    assign Busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            streak   <= '0;
            wait_cnt <= '0;
            is_write <= 1'b0;
            IData    <= '0;
            DRData   <= '0;
            IDone    <= 1'b0;
            DDone    <= 1'b0;
            MemEn    <= 1'b0;
            MemWe    <= '0;
            MemAddr  <= '0;
            MemWData <= '0;
            Owner    <= 1'b0;
        end else begin
            MemEn <= 1'b0;
            MemWe <= '0;
            IDone <= 1'b0;
            DDone <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (IReq || DReq) begin
                        Owner    <= !grant_i;
                        MemAddr  <= grant_i ? IAddr : DAddr;
                        MemWData <= grant_i ? '0 : DWData;
                        is_write <= !grant_i && DWrite;
                        MemEn    <= 1'b1;
                        MemWe    <= (!grant_i && DWrite) ? DStrb : '0;
                        if (grant_i || !IReq) begin
                            streak <= '0;
                        end else if (streak != STK_MAX) begin
                            streak <= streak + 1'b1;
                        end
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (is_write) begin
                        IDone <= !Owner;
                        DDone <= Owner;
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        if (Owner) begin
                            DRData <= MemRData;
                        end else begin
                            IData <= MemRData;
                        end
                        IDone <= !Owner;
                        DDone <= Owner;
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level model predicts grants,
// memory strobes and Done pulses; a monitor compares whatever the DUT presents.
module tb_mem_port_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int RD_LAT = 3;
    localparam int SL     = 2;

    logic          clk;
    logic          rst;
    logic          IReq, DReq, DWrite;
    logic [AW-1:0] IAddr, DAddr;
    logic [DW-1:0] DWData, IData, DRData, MemWData, MemRData;
    logic [SW-1:0] DStrb, MemWe;
    logic          IDone, DDone, MemEn, Busy, Owner;
    logic [AW-1:0] MemAddr;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RD_LAT), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .IReq(IReq), .IAddr(IAddr), .IData(IData), .IDone(IDone),
        .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData), .DStrb(DStrb),
        .DRData(DRData), .DDone(DDone),
        .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData), .Busy(Busy), .Owner(Owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;
    longint cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory environment ----------------
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] pd [RD_LAT];
    bit            pv [RD_LAT];

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return a * 32'h9E37_79B1 ^ 32'h5A5A_1234;
    endfunction

    always @(posedge clk) begin
        logic [DW-1:0] w;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        w     = mem.exists(MemAddr) ? mem[MemAddr] : dflt(MemAddr);
        pv[0] = MemEn;
        pd[0] = w;
        if (MemEn) begin
            for (int b = 0; b < SW; b++)
                if (MemWe[b]) w[8*b +: 8] = MemWData[8*b +: 8];
            mem[MemAddr] = w;
        end
        MemRData <= pv[RD_LAT-1] ? pd[RD_LAT-1] : $urandom();
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit            who;
        longint        at;
        bit            rd;
        logic [DW-1:0] data;
    } done_t;

    typedef struct {
        longint        at;
        logic [AW-1:0] addr;
        logic [SW-1:0] we;
        bit            wr;
        logic [DW-1:0] wdata;
    } acc_t;

    done_t  done_q[$];
    acc_t   acc_q[$];
    int     streak    = 0;
    longint free_at   = 0;
    longint busy_from = 0;
    longint busy_to   = -1;
    bit     exp_owner = 0;
    bit     rst_seen  = 0;
    bit     started   = 0;

    always @(posedge clk) begin
        longint        cur;
        bit            gi, wr;
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        cur      = cyc;
        cyc      = cyc + 1;
        started  = 1;
        rst_seen = rst;
        if (rst) begin
            done_q.delete();
            acc_q.delete();
            streak    = 0;
            free_at   = cur + 1;
            busy_from = 0;
            busy_to   = -1;
            exp_owner = 0;
        end else if (cur >= free_at && (IReq || DReq)) begin
            gi = IReq && (!DReq || streak == SL);
            if (gi || !IReq) streak = 0;
            else streak = (streak + 1 > SL) ? SL : streak + 1;
            wr = !gi && DWrite;
            a  = gi ? IAddr : DAddr;
            v  = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
            acc_q.push_back('{cur + 1, a, wr ? DStrb : '0, wr, DWData});
            done_q.push_back('{!gi, cur + (wr ? 2 : 2 + RD_LAT), !wr, v});
            if (wr) begin
                for (int b = 0; b < SW; b++)
                    if (DStrb[b]) v[8*b +: 8] = DWData[8*b +: 8];
                ref_mem[a] = v;
            end
            exp_owner = !gi;
            busy_from = cur + 1;
            busy_to   = cur + (wr ? 2 : 2 + RD_LAT);
            free_at   = busy_to + 1;
        end
    end

    // ---------------- monitor ----------------
    logic [DW-1:0] exp_i = '0;
    logic [DW-1:0] exp_d = '0;
    bit idone_seen = 0;
    bit ddone_seen = 0;

    always @(negedge clk) begin
        done_t e;
        acc_t  m;
        idone_seen = IDone;
        ddone_seen = DDone;
        if (started) begin
            if (rst_seen) begin
                exp_i = '0;
                exp_d = '0;
                chk("rst_outputs", {IDone, DDone, MemEn, MemWe, Busy, Owner}, '0);
                chk("rst_idata", IData, '0);
                chk("rst_drdata", DRData, '0);
                chk("rst_memaddr", MemAddr, '0);
                chk("rst_memwdata", MemWData, '0);
            end else begin
                chk("busy", Busy, (cyc >= busy_from && cyc <= busy_to));
                chk("owner", Owner, exp_owner);
                if (IDone && DDone) chk("both_done", 2'b11, 2'b01);
                if (IDone || DDone) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", {IDone, DDone}, 2'b00);
                    end else begin
                        e = done_q.pop_front();
                        chk("done_who", {IDone, DDone}, e.who ? 2'b01 : 2'b10);
                        chk("done_cycle", cyc, e.at);
                        if (e.rd) begin
                            if (e.who) exp_d = e.data;
                            else exp_i = e.data;
                        end
                    end
                end else if (done_q.size() > 0 && done_q[0].at <= cyc) begin
                    e = done_q.pop_front();
                    chk("done_missing", cyc, e.at - 1);
                end
                if (MemEn) begin
                    if (acc_q.size() == 0) begin
                        chk("unexpected_memen", MemEn, 1'b0);
                    end else begin
                        m = acc_q.pop_front();
                        chk("memen_cycle", cyc, m.at);
                        chk("mem_addr", MemAddr, m.addr);
                        chk("mem_we", MemWe, m.we);
                        if (m.wr) chk("mem_wdata", MemWData, m.wdata);
                    end
                end else if (acc_q.size() > 0 && acc_q[0].at <= cyc) begin
                    m = acc_q.pop_front();
                    chk("memen_missing", cyc, m.at - 1);
                end
                chk("idata", IData, exp_i);
                chk("drdata", DRData, exp_d);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit ipend = 0;
    bit dpend = 0;

    function automatic logic [AW-1:0] rand_addr();
        return 32'h1000 + {26'd0, 4'($urandom_range(15)), 2'b00};
    endfunction

    task automatic tick(input int pi, input int pd_pct);
        @(posedge clk);
        #1;
        if (ipend && idone_seen) ipend = 0;
        if (dpend && ddone_seen) dpend = 0;
        if (!ipend && $urandom_range(99) < pi) begin
            ipend = 1;
            IAddr = rand_addr();
        end
        if (!dpend && $urandom_range(99) < pd_pct) begin
            dpend  = 1;
            DAddr  = rand_addr();
            DWrite = 1'($urandom_range(1));
            DWData = $urandom();
            DStrb  = SW'($urandom_range(15));
        end
        IReq = ipend;
        DReq = dpend;
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        ipend = 0;
        dpend = 0;
        IReq  = 1'b0;
        DReq  = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic req_i(input logic [AW-1:0] a);
        ipend = 1;
        IAddr = a;
        IReq  = 1'b1;
    endtask

    task automatic req_d(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
        dpend  = 1;
        DWrite = w;
        DAddr  = a;
        DWData = d;
        DStrb  = s;
        DReq   = 1'b1;
    endtask

    initial begin
        rst    = 1'b1;
        IReq   = 1'b0;
        DReq   = 1'b0;
        DWrite = 1'b0;
        IAddr  = '0;
        DAddr  = '0;
        DWData = '0;
        DStrb  = '0;
        mem[32'h100]     = 32'hDEAD_BEEF;
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        tick(0, 0);

        // Lone fetch of a preloaded word
        req_i(32'h100);
        repeat (10) tick(0, 0);
        // Partial store, then read it back via fetch
        req_d(1'b1, 32'h2000, 32'h1234_5678, 4'b0011);
        repeat (6) tick(0, 0);
        req_i(32'h2000);
        repeat (10) tick(0, 0);
        // Zero-strobe store still strobes memory
        req_d(1'b1, 32'h2000, 32'hFFFF_FFFF, 4'b0000);
        repeat (6) tick(0, 0);
        // Simultaneous I and D store: D first, then I
        req_i(32'h2000);
        req_d(1'b1, 32'h2004, 32'hCAFE_F00D, 4'b1111);
        repeat (14) tick(0, 0);
        // Continuous contention exercises the starvation guard
        repeat (60) tick(100, 100);
        repeat (16) tick(0, 0);

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(299) == 0) apply_reset();
            else tick(40, 50);
        end
        repeat (16) tick(0, 0);

        // Reset during the WAIT of a load after DRData holds a value
        req_d(1'b0, 32'h100, '0, '0);
        repeat (10) tick(0, 0);
        req_d(1'b0, 32'h1004, '0, '0);
        tick(0, 0);
        tick(0, 0);
        apply_reset();
        repeat (10) tick(0, 0);
        // Normal service right after reset
        req_i(32'h100);
        repeat (12) tick(0, 0);

        chk("drain_done_q", done_q.size(), 0);
        chk("drain_acc_q", acc_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
